mp3_bus_sched: RTL and testbench

Serial-bus scheduler for the VS1003 decoder port, running on `clk_1M` alongside the music ROM.
- Owns the single SI/SCK pair and the XCS/XDCS strobes, and shares them between two requesters: SCI register writes (volume control from the UI) and SDI audio words from the ROM fetch path.
- Paces every transfer on DREQ and arbitrates only at word boundaries.
- Hardware reset (XRSET) and the power-up delay are sequenced outside this block.

---
 rtl/mp3_pkg.sv | 24 ++
 rtl/mp3_spi_shift.sv | 61 ++++++
 rtl/mp3_bus_sched.sv | 154 +++++++++++++++
 tb/tb_mp3_bus_sched.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp3_pkg.sv
// Shared types and constants for the VS1003 serial-bus scheduler.
// Frame helper builds a 32-bit SCI write frame.
package mp3_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCI_SHIFT,
      ST_SDI_SHIFT,
      ST_GAP
   } state_e;

   localparam logic [7:0]  SCI_WRITE_OP  = 8'h02;
   localparam logic [7:0]  SCI_MODE_ADDR = 8'h00;
   localparam logic [7:0]  SCI_VOL_ADDR  = 8'h0B;
   localparam logic [15:0] MODE_SOFTRST  = 16'h0804;

   localparam int unsigned SCI_FRAME_W = 32;
   localparam int unsigned SDI_FRAME_W = 16;

   function automatic logic [31:0] sci_frame(input logic [7:0] addr, input logic [15:0] data);
      return {SCI_WRITE_OP, addr, data};
   endfunction

endpackage

// File: rtl/mp3_spi_shift.sv
// MSB-first shifter for SCI (32-bit) and SDI (16-bit) words; two clk_1M cycles per bit.
// done_o flags the SCK-high half of the final bit.
module mp3_spi_shift
   import mp3_pkg::*;
(
   input  logic        clk_1M,
   input  logic        rst,
   input  logic        load_i,
   input  logic        len32_i,
   input  logic [31:0] data_i,
   output logic        si_o,
   output logic        sck_o,
   output logic        done_o
);

   logic [31:0] sh_q, sh_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        ph_q, ph_d;
   logic        act_q, act_d;

   always_comb begin
      sh_d  = sh_q;
      cnt_d = cnt_q;
      ph_d  = ph_q;
      act_d = act_q;
      if (load_i) begin
         sh_d  = data_i;
         cnt_d = len32_i ? 5'(SCI_FRAME_W - 1) : 5'(SDI_FRAME_W - 1);
         ph_d  = 1'b0;
         act_d = 1'b1;
      end else if (act_q) begin
         if (!ph_q) begin
            ph_d = 1'b1;
         end else begin
            ph_d  = 1'b0;
            sh_d  = {sh_q[30:0], 1'b0};
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd0) act_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_1M) begin
      if (rst) begin
         sh_q  <= '0;
         cnt_q <= '0;
         ph_q  <= 1'b0;
         act_q <= 1'b0;
      end else begin
         sh_q  <= sh_d;
         cnt_q <= cnt_d;
         ph_q  <= ph_d;
         act_q <= act_d;
      end
   end

   assign si_o   = act_q & sh_q[31];
   assign sck_o  = act_q & ph_q;
   assign done_o = act_q & ph_q & (cnt_q == 5'd0);

endmodule

// File: rtl/mp3_bus_sched.sv
// VS1003 bus scheduler: shares SI/SCK between SCI volume writes and SDI audio words, paced on DREQ.
// Optional MP3_SCHED_SOFTRST_EN adds a soft-reset SCI frame request (srst_req).
module mp3_bus_sched
   import mp3_pkg::*;
#(
   parameter logic [7:0]  VOL_ADDR = SCI_VOL_ADDR,
   parameter int unsigned GAP_CYC  = 2
) (
   input  logic        clk_1M,
   input  logic        rst,
   input  logic        enable,
   input  logic        DREQ,
   input  logic        vol_req,
   input  logic [15:0] vol_val,
   output logic        vol_busy,
`ifdef MP3_SCHED_SOFTRST_EN
   input  logic        srst_req,
`endif
   input  logic        dat_valid,
   input  logic [15:0] dat_word,
   output logic        dat_ready,
   output logic        XCS,
   output logic        XDCS,
   output logic        SI,
   output logic        SCK
);

   // The IDLE arbitration cycle is the last of the GAP_CYC deselected cycles.
   localparam logic [3:0] GAP_LOAD = 4'(GAP_CYC - 2);

   state_e      state_q, state_d;
   logic        pend_q, pend_d;
   logic [15:0] pend_val_q, pend_val_d;
   logic [3:0]  gap_q, gap_d;
   logic        rdy_q, rdy_d;
   logic        dreq_q;
   logic        load, len32, done;
   logic [31:0] frame;
`ifdef MP3_SCHED_SOFTRST_EN
   logic        pend_srst_q, pend_srst_d;
   logic        srst_wait_q, srst_wait_d;
`endif

   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      gap_d      = gap_q;
      rdy_d      = 1'b0;
      load       = 1'b0;
      len32      = 1'b0;
      frame      = '0;
`ifdef MP3_SCHED_SOFTRST_EN
      pend_srst_d = pend_srst_q | srst_req;
      srst_wait_d = srst_wait_q;
`endif
      case (state_q)
         ST_IDLE: begin
`ifdef MP3_SCHED_SOFTRST_EN
            // After a soft reset hold off until the decoder drops DREQ once.
            if (srst_wait_q) begin
               if (!dreq_q) srst_wait_d = 1'b0;
            end else if (dreq_q && pend_srst_q) begin
               state_d     = ST_SCI_SHIFT;
               load        = 1'b1;
               len32       = 1'b1;
               frame       = sci_frame(SCI_MODE_ADDR, MODE_SOFTRST);
               pend_srst_d = srst_req;
               srst_wait_d = 1'b1;
            end else
`endif
            if (dreq_q && pend_q) begin
               state_d = ST_SCI_SHIFT;
               load    = 1'b1;
               len32   = 1'b1;
               frame   = sci_frame(VOL_ADDR, pend_val_q);
               pend_d  = 1'b0;
            end else if (dreq_q && enable && dat_valid) begin
               state_d = ST_SDI_SHIFT;
               load    = 1'b1;
               frame   = {dat_word, 16'h0000};
               rdy_d   = 1'b1;
            end
         end
         ST_SCI_SHIFT, ST_SDI_SHIFT: begin
            if (done) begin
               if (GAP_CYC > 1) begin
                  state_d = ST_GAP;
                  gap_d   = GAP_LOAD;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (gap_q == 4'd0) state_d = ST_IDLE;
            else               gap_d   = gap_q - 4'd1;
         end
         default: state_d = ST_IDLE;
      endcase
      // A request in the launch cycle re-arms for a following frame.
      if (vol_req) begin
         pend_d     = 1'b1;
         pend_val_d = vol_val;
      end
   end

   always_ff @(posedge clk_1M) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pend_q     <= 1'b0;
         pend_val_q <= '0;
         gap_q      <= '0;
         rdy_q      <= 1'b0;
         dreq_q     <= 1'b0;
`ifdef MP3_SCHED_SOFTRST_EN
         pend_srst_q <= 1'b0;
         srst_wait_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         pend_val_q <= pend_val_d;
         gap_q      <= gap_d;
         rdy_q      <= rdy_d;
         dreq_q     <= DREQ;
`ifdef MP3_SCHED_SOFTRST_EN
         pend_srst_q <= pend_srst_d;
         srst_wait_q <= srst_wait_d;
`endif
      end
   end

   mp3_spi_shift u_shift (
      .clk_1M  (clk_1M),
      .rst     (rst),
      .load_i  (load),
      .len32_i (len32),
      .data_i  (frame),
      .si_o    (SI),
      .sck_o   (SCK),
      .done_o  (done)
   );

   assign XCS       = (state_q != ST_SCI_SHIFT);
   assign XDCS      = (state_q != ST_SDI_SHIFT);
   assign dat_ready = rdy_q;
`ifdef MP3_SCHED_SOFTRST_EN
   assign vol_busy  = pend_q | pend_srst_q | (state_q == ST_SCI_SHIFT);
`else
   assign vol_busy  = pend_q | (state_q == ST_SCI_SHIFT);
`endif

endmodule

// File: tb/tb_mp3_bus_sched.sv
// Bench for mp3_bus_sched: word-level reference model compared every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_mp3_bus_sched;

   localparam int GAP = 2;

   logic        clk_1M;
   logic        rst, enable, DREQ, vol_req, dat_valid;
   logic [15:0] vol_val, dat_word;
   logic        vol_busy, dat_ready, XCS, XDCS, SI, SCK;

   mp3_bus_sched #(.VOL_ADDR(8'h0B), .GAP_CYC(GAP)) dut (
      .clk_1M    (clk_1M),
      .rst       (rst),
      .enable    (enable),
      .DREQ      (DREQ),
      .vol_req   (vol_req),
      .vol_val   (vol_val),
      .vol_busy  (vol_busy),
      .dat_valid (dat_valid),
      .dat_word  (dat_word),
      .dat_ready (dat_ready),
      .XCS       (XCS),
      .XDCS      (XDCS),
      .SI        (SI),
      .SCK       (SCK)
   );

   initial begin
      clk_1M = 1'b0;
      forever #5 clk_1M = ~clk_1M;
   end

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each started word is expanded into its expected
   // per-cycle waveform (sel 1=SCI, 2=SDI), followed by deselected gap cycles.
   typedef struct packed {
      logic [1:0] sel;
      logic       si;
      logic       sck;
   } cyc_t;

   cyc_t        q[$];
   cyc_t        m_cur;
   bit          m_idle = 1'b1;
   bit          m_pend, m_dq, m_rdy, m_valid;
   logic [15:0] m_pv;

   task automatic push_word(input logic [1:0] sel, input logic [31:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         q.push_back('{sel, bits[i], 1'b0});
         q.push_back('{sel, bits[i], 1'b1});
      end
      for (int i = 0; i < GAP - 1; i++) q.push_back('{2'd0, 1'b0, 1'b0});
   endtask

   task automatic model_step();
      if (rst) begin
         q.delete();
         m_idle = 1'b1;
         m_pend = 1'b0;
         m_pv   = '0;
         m_dq   = 1'b0;
         m_rdy  = 1'b0;
         m_cur  = '0;
      end else begin
         m_rdy = 1'b0;
         if (m_idle && m_dq) begin
            if (m_pend) begin
               push_word(2'd1, {8'h02, 8'h0B, m_pv}, 32);
               m_pend = 1'b0;
            end else if (enable && dat_valid) begin
               push_word(2'd2, {16'h0000, dat_word}, 16);
               m_rdy = 1'b1;
            end
         end
         if (vol_req) begin
            m_pend = 1'b1;
            m_pv   = vol_val;
         end
         m_dq = DREQ;
         if (q.size() > 0) begin
            m_cur  = q.pop_front();
            m_idle = 1'b0;
         end else begin
            m_cur  = '0;
            m_idle = 1'b1;
         end
      end
      m_valid = 1'b1;
   endtask

   function automatic logic [5:0] exp_vec();
      return {m_cur.sel != 2'd1, m_cur.sel != 2'd2, m_cur.si, m_cur.sck,
              m_rdy, m_pend | (m_cur.sel == 2'd1)};
   endfunction

   task automatic tick();
      @(posedge clk_1M);
      model_step();
      @(negedge clk_1M);
      #1;
   endtask

   // Compare process plus a bus monitor that decodes select windows.
   int          rdy_cnt  = 0;
   int          win_len  = 0;
   int          win_kind = 0;
   int          win_gap  = 0;
   int          idle_run = 0;
   int          cap_bits = 0;
   logic [31:0] cap      = '0;
   logic        prev_sck = 1'b0;
   int          log_kind[$];
   int          log_len[$];
   int          log_gap[$];
   logic [31:0] log_data[$];

   initial begin
      forever begin
         @(negedge clk_1M);
         if (m_valid) check("outputs{XCS,XDCS,SI,SCK,rdy,busy}",
                            {XCS, XDCS, SI, SCK, dat_ready, vol_busy}, exp_vec());
         if (dat_ready) rdy_cnt++;
         if (!XCS || !XDCS) begin
            if (win_len == 0) begin
               win_gap  = idle_run;
               win_kind = !XCS ? 1 : 2;
            end
            win_len++;
            idle_run = 0;
            if (SCK && !prev_sck) begin
               cap = {cap[30:0], SI};
               cap_bits++;
            end
         end else begin
            if (win_len > 0) begin
               log_kind.push_back(win_kind);
               log_len.push_back(win_len);
               log_gap.push_back(win_gap);
               log_data.push_back(cap);
               win_len  = 0;
               cap      = '0;
               cap_bits = 0;
            end
            idle_run++;
         end
         prev_sck = SCK;
      end
   end

   task automatic wait_log(input int n, input int lim);
      for (int i = 0; i < lim && log_len.size() < n; i++) tick();
      check("wait_log_count", log_len.size(), n);
   endtask

   task automatic wait_rdy(input int n, input int lim);
      for (int i = 0; i < lim && rdy_cnt < n; i++) tick();
      check("wait_rdy_count", rdy_cnt, n);
   endtask

   int n0, r0;

   initial begin
      rst = 1'b1; DREQ = 1'b1; enable = 1'b0; vol_req = 1'b0; vol_val = '0;
      dat_valid = 1'b0; dat_word = '0;
      repeat (3) tick();
      check("rst_XCS", XCS, 1);
      check("rst_XDCS", XDCS, 1);
      check("rst_SI", SI, 0);
      check("rst_SCK", SCK, 0);
      check("rst_dat_ready", dat_ready, 0);
      check("rst_vol_busy", vol_busy, 0);
      rst = 1'b0;
      repeat (100) tick();
      check("idle_no_window", log_len.size(), 0);
      check("idle_no_rdy", rdy_cnt, 0);
      check("idle_sel_sck", {XCS, XDCS, SCK}, 3'b110);

      // Volume write timing and frame content.
      vol_val = 16'h2020; vol_req = 1'b1;
      tick();
      vol_req = 1'b0; vol_val = '0;
      check("vol_t_busy", vol_busy, 1);
      check("vol_t_xcs_high", XCS, 1);
      tick();
      check("vol_t1_xcs_si_sck", {XCS, SI, SCK}, 3'b000);
      tick();
      check("vol_t2_sck", SCK, 1);
      n0 = log_len.size();
      wait_log(n0 + 1, 200);
      check("sci_kind", log_kind[n0], 1);
      check("sci_len", log_len[n0], 64);
      check("sci_data", log_data[n0], 32'h020B2020);
      check("sci_busy_after", vol_busy, 0);

      // Two back-to-back SDI words.
      r0 = rdy_cnt; n0 = log_len.size();
      enable = 1'b1; dat_valid = 1'b1; dat_word = 16'hFFFB;
      wait_rdy(r0 + 1, 50);
      dat_word = 16'h9040;
      wait_rdy(r0 + 2, 200);
      dat_valid = 1'b0;
      wait_log(n0 + 2, 200);
      check("sdi0_kind", log_kind[n0], 2);
      check("sdi0_len", log_len[n0], 32);
      check("sdi0_data", log_data[n0], 32'h0000FFFB);
      check("sdi1_len", log_len[n0 + 1], 32);
      check("sdi1_data", log_data[n0 + 1], 32'h00009040);
      check("sdi1_gap", log_gap[n0 + 1], GAP);
      check("sdi_rdy_pulses", rdy_cnt - r0, 2);

      // Volume request during an SDI word slots in before the next word.
      r0 = rdy_cnt; n0 = log_len.size();
      dat_word = 16'hA5C3; dat_valid = 1'b1;
      wait_rdy(r0 + 1, 50);
      dat_word = 16'h5A3C;
      repeat (10) tick();
      vol_val = 16'h1010; vol_req = 1'b1;
      tick();
      vol_req = 1'b0;
      wait_rdy(r0 + 2, 300);
      dat_valid = 1'b0;
      wait_log(n0 + 3, 300);
      check("mix0_kind", log_kind[n0], 2);
      check("mix0_data", log_data[n0], 32'h0000A5C3);
      check("mix1_kind", log_kind[n0 + 1], 1);
      check("mix1_data", log_data[n0 + 1], 32'h020B1010);
      check("mix2_kind", log_kind[n0 + 2], 2);
      check("mix2_data", log_data[n0 + 2], 32'h00005A3C);

      // DREQ low in IDLE blocks pending data; start follows two edges after rise.
      repeat (20) tick();
      DREQ = 1'b0;
      tick();
      n0 = log_len.size(); r0 = rdy_cnt;
      dat_word = 16'hC0DE; dat_valid = 1'b1;
      repeat (40) tick();
      check("dreq_low_no_window", log_len.size(), n0);
      check("dreq_low_no_rdy", rdy_cnt, r0);
      check("dreq_low_sel", {XCS, XDCS}, 2'b11);
      DREQ = 1'b1;
      tick();
      check("dreq_e1_xdcs", XDCS, 1);
      tick();
      check("dreq_e2_xdcs", XDCS, 0);
      check("dreq_e2_rdy", dat_ready, 1);
      dat_valid = 1'b0;
      wait_log(n0 + 1, 100);
      check("dreq_data", log_data[n0], 32'h0000C0DE);

      // Reset in the middle of an SCI frame drops it.
      enable = 1'b0;
      repeat (20) tick();
      vol_val = 16'h1234; vol_req = 1'b1;
      tick();
      vol_req = 1'b0;
      for (int i = 0; i < 20 && XCS; i++) tick();
      check("rst_mid_xcs_low", XCS, 0);
      for (int i = 0; i < 100 && cap_bits < 20; i++) tick();
      check("rst_mid_bits", cap_bits, 20);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_XCS", XCS, 1);
      check("rst_mid_SCK", SCK, 0);
      check("rst_mid_SI", SI, 0);
      check("rst_mid_busy", vol_busy, 0);
      n0 = log_len.size(); r0 = rdy_cnt;
      repeat (150) tick();
      check("rst_mid_no_resume", log_len.size(), n0);
      check("rst_mid_no_rdy", rdy_cnt, r0);

      // Randomized traffic against the model.
      enable = 1'b1;
      for (int c = 0; c < 5000; c++) begin
         if ($urandom_range(0, 19) == 0) DREQ = ~DREQ;
         if ($urandom_range(0, 49) == 0) enable = ~enable;
         dat_valid = ($urandom_range(0, 9) < 7);
         dat_word  = 16'($urandom);
         vol_req   = ($urandom_range(0, 119) == 0);
         vol_val   = 16'($urandom);
         rst       = ($urandom_range(0, 999) == 0);
         tick();
      end
      rst = 1'b0; vol_req = 1'b0; dat_valid = 1'b0;
      repeat (100) tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
